// File: rtl/tick_meter.sv
// tick_meter: samples an asynchronous square-wave tick on src_clk, measures
// each half-period in src_clk cycles, and reports lock, stall and edge stats.
module tick_meter #(
  parameter int SRC_FREQ  = 5000,
  parameter int TICK_FREQ = 1,
  parameter int TOL       = 2,
  parameter int LOCK_N    = 2
) (
  input  logic        src_clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        tick_in,
  output logic        edge_seen,
  output logic [31:0] half_period,
  output logic        period_valid,
  output logic        locked,
  output logic        stalled,
  output logic [15:0] edge_count
);

  localparam int          HALF      = SRC_FREQ / TICK_FREQ / 2;
  localparam int          TIMEOUT   = 2 * HALF + TOL;
  localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);
  localparam logic [15:0] LOCK_C    = 16'(LOCK_N);

  typedef enum logic {IDLE, MEAS} state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [15:0] match_cnt;
  logic [15:0] match_inc;

  // tick_p0/tick_p1 form the two-flop synchronizer, tick_p2 is the previous level
  logic tick_p0, tick_p1, tick_p2;
  logic edge_det;

  // Saturating half-period counter; never passes the stall timeout
  function automatic logic [31:0] sat_cnt(input logic [31:0] c);
    return (c >= TIMEOUT_C) ? TIMEOUT_C : c + 32'd1;
  endfunction

  // Saturating consecutive-match counter, clamps at LOCK_N
  function automatic logic [15:0] sat_match(input logic [15:0] m);
    return (m >= LOCK_C) ? LOCK_C : m + 16'd1;
  endfunction

  // |meas - HALF| <= TOL, evaluated signed so a short period cannot wrap
  function automatic logic in_tol(input logic [31:0] m);
    logic signed [33:0] d;
    d = $signed({2'b00, m}) - $signed(34'(HALF));
    return (d <= $signed(34'(TOL))) && (d >= -$signed(34'(TOL)));
  endfunction

  assign match_inc = sat_match(match_cnt);

  // Synchronizer and edge history; runs regardless of enable so re-enable is clean
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_p0 <= 1'b0;
      tick_p1 <= 1'b0;
      tick_p2 <= 1'b0;
    end else begin
      tick_p0 <= tick_in;
      tick_p1 <= tick_p0;
      tick_p2 <= tick_p1;
    end
  end

  // ---- stage boundary: synchronized level -> edge detect ----
  assign edge_det = tick_p1 ^ tick_p2;

  // Measurement FSM: counts cycles between edges, judges tolerance, detects stalls
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 32'd0;
      match_cnt    <= 16'd0;
      half_period  <= 32'd0;
      edge_count   <= 16'd0;
      edge_seen    <= 1'b0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      stalled      <= 1'b0;
    end else if (!enable) begin
      state        <= IDLE;
      cnt          <= 32'd0;
      match_cnt    <= 16'd0;
      locked       <= 1'b0;
      stalled      <= 1'b0;
      edge_seen    <= 1'b0;
      period_valid <= 1'b0;
    end else begin
      edge_seen    <= edge_det;
      period_valid <= 1'b0;
      if (edge_det) edge_count <= edge_count + 16'd1;
      case (state)
        IDLE: begin
          if (edge_det) begin
            // First edge only opens a measurement window
            state   <= MEAS;
            cnt     <= 32'd1;
            stalled <= 1'b0;
          end else begin
            cnt <= 32'd0;
          end
        end
        MEAS: begin
          if (edge_det) begin
            // An edge arriving with cnt at TIMEOUT still counts as a measurement
            half_period  <= cnt;
            period_valid <= 1'b1;
            cnt          <= 32'd1;
            stalled      <= 1'b0;
            if (in_tol(cnt)) begin
              match_cnt <= match_inc;
              locked    <= (match_inc == LOCK_C);
            end else begin
              match_cnt <= 16'd0;
              locked    <= 1'b0;
            end
          end else if (cnt >= TIMEOUT_C) begin
            stalled   <= 1'b1;
            locked    <= 1'b0;
            match_cnt <= 16'd0;
            cnt       <= 32'd0;
            state     <= IDLE;
          end else begin
            cnt <= sat_cnt(cnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tick_meter.sv
// tb_tick_meter: directed table-driven bench for tick_meter with
// HALF=10, TOL=1, LOCK_N=2, TIMEOUT=21.
module tb_tick_meter;

  logic        src_clk;
  logic        rst_n;
  logic        enable;
  logic        tick_in;
  logic        edge_seen;
  logic [31:0] half_period;
  logic        period_valid;
  logic        locked;
  logic        stalled;
  logic [15:0] edge_count;

  int n_cmp = 0;
  int n_bad = 0;

  tick_meter #(.SRC_FREQ(20), .TICK_FREQ(1), .TOL(1), .LOCK_N(2)) dut (
    .src_clk(src_clk), .rst_n(rst_n), .enable(enable), .tick_in(tick_in),
    .edge_seen(edge_seen), .half_period(half_period), .period_valid(period_valid),
    .locked(locked), .stalled(stalled), .edge_count(edge_count)
  );

  initial src_clk = 1'b0;
  always #5 src_clk = ~src_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  // en, tog, n cycles, #edge_seen, #period_valid, half_period, locked,
  // locked at period_valid, stalled, edge_count (all at end of window)
  typedef struct {
    logic en; logic tog; int n; int es; int pv; int hp;
    logic lk; logic lkpv; logic st; int ec;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, longint'({edge_seen, half_period, period_valid, locked, stalled, edge_count}), 0);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int es_c, pv_c;
    logic lk_pv;
    es_c = 0; pv_c = 0; lk_pv = 1'b0;
    enable = v.en;
    if (v.tog) tick_in = ~tick_in;
    repeat (v.n) begin
      @(negedge src_clk);
      if (edge_seen) es_c++;
      if (period_valid) begin
        pv_c++;
        lk_pv = locked;
      end
    end
    chk({tag, ".edge_seen"}, es_c, v.es);
    chk({tag, ".period_valid"}, pv_c, v.pv);
    chk({tag, ".half_period"}, half_period, v.hp);
    chk({tag, ".locked"}, locked, v.lk);
    chk({tag, ".stalled"}, stalled, v.st);
    chk({tag, ".edge_count"}, edge_count, v.ec);
    if (v.pv > 0) chk({tag, ".locked_at_pv"}, lk_pv, v.lkpv);
  endtask

  initial begin
    vec_t va, vb;
    int es_c;
    // lock-in
    tbl[0]  = '{1'b1, 1'b1, 10, 1, 0,  0, 1'b0, 1'b0, 1'b0,  1};
    tbl[1]  = '{1'b1, 1'b1, 10, 1, 1, 10, 1'b0, 1'b0, 1'b0,  2};
    tbl[2]  = '{1'b1, 1'b1, 11, 1, 1, 10, 1'b1, 1'b1, 1'b0,  3};
    // tolerance: 11 keeps lock, 12 drops it, two 10s regain it
    tbl[3]  = '{1'b1, 1'b1, 12, 1, 1, 11, 1'b1, 1'b1, 1'b0,  4};
    tbl[4]  = '{1'b1, 1'b1, 10, 1, 1, 12, 1'b0, 1'b0, 1'b0,  5};
    tbl[5]  = '{1'b1, 1'b1, 10, 1, 1, 10, 1'b0, 1'b0, 1'b0,  6};
    // stall after 25 quiet cycles, recovery
    tbl[6]  = '{1'b1, 1'b1, 25, 1, 1, 10, 1'b0, 1'b1, 1'b1,  7};
    tbl[7]  = '{1'b1, 1'b1, 10, 1, 0, 10, 1'b0, 1'b0, 1'b0,  8};
    // edge coincides with cnt == TIMEOUT: recorded as 21, out of tolerance
    tbl[8]  = '{1'b1, 1'b1, 21, 1, 1, 10, 1'b0, 1'b0, 1'b0,  9};
    tbl[9]  = '{1'b1, 1'b1, 10, 1, 1, 21, 1'b0, 1'b0, 1'b0, 10};
    // enable gating
    tbl[10] = '{1'b0, 1'b1, 10, 0, 0, 21, 1'b0, 1'b0, 1'b0, 10};
    tbl[11] = '{1'b0, 1'b1, 10, 0, 0, 21, 1'b0, 1'b0, 1'b0, 10};
    tbl[12] = '{1'b0, 1'b1, 10, 0, 0, 21, 1'b0, 1'b0, 1'b0, 10};
    tbl[13] = '{1'b1, 1'b0, 10, 0, 0, 21, 1'b0, 1'b0, 1'b0, 10};
    tbl[14] = '{1'b1, 1'b1, 10, 1, 0, 21, 1'b0, 1'b0, 1'b0, 11};
    tbl[15] = '{1'b1, 1'b1, 10, 1, 1, 10, 1'b0, 1'b0, 1'b0, 12};

    enable = 1'b1;
    tick_in = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_zero("reset_async");

    // tick toggles while held in reset
    for (int i = 0; i < 3; i++) begin
      @(negedge src_clk);
      tick_in = ~tick_in;
      @(negedge src_clk);
      chk_zero($sformatf("reset_hold%0d", i));
    end

    // release with tick_in high: edge_seen exactly on the 3rd cycle
    rst_n = 1'b1;
    es_c = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge src_clk);
      chk($sformatf("release_es_c%0d", i), edge_seen, (i == 3) ? 1 : 0);
    end
    chk("release_pv", period_valid, 0);
    chk("release_ec", edge_count, 1);

    // reassert asynchronously mid-cycle with nonzero state
    rst_n = 1'b0;
    tick_in = 1'b0;
    #1 chk_zero("reset_again");
    repeat (2) @(negedge src_clk);
    rst_n = 1'b1;
    @(negedge src_clk);

    for (int i = 0; i < 16; i++) run_vec($sformatf("v%0d", i), tbl[i]);

    // async reset mid-measurement at cnt = 5
    enable = 1'b1;
    tick_in = ~tick_in;
    repeat (7) @(negedge src_clk);
    chk("midcnt_ec", edge_count, 13);
    chk("midcnt_hp", half_period, 10);
    rst_n = 1'b0;
    #1 chk_zero("midcnt_reset");
    repeat (2) @(negedge src_clk);
    rst_n = 1'b1;
    es_c = 0;
    repeat (3) begin
      @(negedge src_clk);
      if (edge_seen) es_c++;
    end
    chk("midcnt_static_es", es_c, 0);
    va = '{1'b1, 1'b1, 10, 1, 0,  0, 1'b0, 1'b0, 1'b0, 1};
    vb = '{1'b1, 1'b1, 10, 1, 1, 10, 1'b0, 1'b0, 1'b0, 2};
    run_vec("post_rst0", va);
    run_vec("post_rst1", vb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
